// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered mul/div results, 1-cycle registered write.
// Backpressure: md_ready drops when the FIFO is full; pipe_stall holds the pipeline on hazard or forced drain.
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pipe_valid,
  input  logic [ADDR_W-1:0]               pipe_waddr,
  input  logic [DATA_W-1:0]               pipe_wdata,
  output logic                            pipe_stall,
  input  logic                            md_valid,
  input  logic [ADDR_W-1:0]               md_waddr,
  input  logic [DATA_W-1:0]               md_wdata,
  output logic                            md_ready,
  output logic                            rf_we,
  output logic [ADDR_W-1:0]               rf_waddr,
  output logic [DATA_W-1:0]               rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]     md_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];

  logic pipe_wr, fifo_empty, hazard, enq, grant_md, grant_pipe;

  assign pipe_wr    = pipe_valid && (pipe_waddr != '0);
  assign fifo_empty = (count_q == '0);
  assign md_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  // Address-zero results complete the handshake but are never stored.
  assign enq        = md_valid && md_ready && (md_waddr != '0);

  // Only entries between the read pointer and the occupancy count are live.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hazard = 1'b0;
    idx    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && fifo_addr_q[idx] == pipe_waddr && pipe_wr)
        hazard = 1'b1;
    end
  end

  always_comb begin
    grant_md   = 1'b0;
    grant_pipe = 1'b0;
    pipe_stall = 1'b0;
    if (state_q == FORCE) begin
      grant_md   = !fifo_empty;
      pipe_stall = pipe_wr;
    end else if (hazard) begin
      grant_md   = 1'b1;
      pipe_stall = 1'b1;
    end else if (pipe_wr) begin
      grant_pipe = 1'b1;
    end else begin
      grant_md   = !fifo_empty;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(grant_md);
    count_d  = count_q + CNT_W'(enq) - CNT_W'(grant_md);

    age_d = age_q;
    if (grant_md || fifo_empty)
      age_d = '0;
    else if (age_q < AGE_W'(MAX_WAIT))
      age_d = age_q + AGE_W'(1);

    state_d = state_q;
    if (state_q == NORMAL) begin
      if (count_d == CNT_W'(FIFO_DEPTH) || age_d >= AGE_W'(MAX_WAIT))
        state_d = FORCE;
    end else if (count_d == '0) begin
      state_d = NORMAL;
    end

    rf_we_d    = grant_md || grant_pipe;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_md) begin
      rf_waddr_d = fifo_addr_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (grant_pipe) begin
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      age_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Payload storage needs no reset: occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= md_waddr;
      fifo_data_q[wr_ptr_q] <= md_wdata;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign md_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scenario bench for wb_write_arbiter: expected register writes are queued as stimulus is driven.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        md_valid;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  md_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  wb_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata), .md_ready(md_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .md_count(md_count)
  );

  always #5 clk = ~clk;

  // Every register write is matched in order against the expected queue.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected none", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          bad++;
          $display("FAIL write_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d writes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pipe_valid = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    md_valid = 1'b0; md_waddr = '0; md_wdata = '0;
    #12;
    total++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || md_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h count=%0d, expected all 0",
               rf_we, rf_waddr, rf_wdata, md_count);
    end
    total++;
    if (md_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: md_ready=%b pipe_stall=%b, expected 1/0", md_ready, pipe_stall);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_only();
    pipe_valid = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
    for (int i = 0; i < 3; i++) begin
      expect_wr(5'd3, 32'h11);
      #1;
      total++;
      if (pipe_stall !== 1'b0 || md_count !== 3'd0) begin
        bad++;
        $display("FAIL pipe_only_stall: stall=%b count=%0d, expected 0/0", pipe_stall, md_count);
      end
      tick();
    end
    pipe_valid = 1'b0;
    drain("pipe_only");
    total++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      bad++;
      $display("FAIL idle_hold: we=%b addr=%0d data=%h, expected 0/3/00000011", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_md_single();
    md_valid = 1'b1; md_waddr = 5'd7; md_wdata = 32'hABCD;
    expect_wr(5'd7, 32'hABCD);
    tick();
    md_valid = 1'b0;
    #1;
    total++;
    if (md_count !== 3'd1) begin
      bad++;
      $display("FAIL md_single_count1: got %0d, expected 1", md_count);
    end
    tick();
    total++;
    if (md_count !== 3'd0) begin
      bad++;
      $display("FAIL md_single_count0: got %0d, expected 0", md_count);
    end
    drain("md_single");
  endtask

  task automatic test_force_full();
    pipe_valid = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h44;
    for (int i = 0; i < 4; i++) begin
      md_valid = 1'b1; md_waddr = 5'(8 + i); md_wdata = 32'h80 + 32'(i);
      expect_wr(5'd4, 32'h44);
      #1;
      total++;
      if (pipe_stall !== 1'b0 || md_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_stall: stall=%b ready=%b, expected 0/1", pipe_stall, md_ready);
      end
      tick();
    end
    md_valid = 1'b0;
    #1;
    total++;
    if (md_ready !== 1'b0 || md_count !== 3'd4) begin
      bad++;
      $display("FAIL full_ready: ready=%b count=%0d, expected 0/4", md_ready, md_count);
    end
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'(8 + i), 32'h80 + 32'(i));
      total++;
      if (pipe_stall !== 1'b1) begin
        bad++;
        $display("FAIL force_stall[%0d]: got %b, expected 1", i, pipe_stall);
      end
      tick();
    end
    total++;
    if (pipe_stall !== 1'b0 || md_count !== 3'd0) begin
      bad++;
      $display("FAIL force_exit: stall=%b count=%0d, expected 0/0", pipe_stall, md_count);
    end
    expect_wr(5'd4, 32'h44);
    tick();
    pipe_valid = 1'b0;
    drain("force_full");
  endtask

  task automatic test_age();
    md_valid = 1'b1; md_waddr = 5'd9; md_wdata = 32'h99;
    pipe_valid = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h55;
    expect_wr(5'd5, 32'h55);
    tick();
    md_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_wr(5'd5, 32'h55);
      total++;
      if (pipe_stall !== 1'b0) begin
        bad++;
        $display("FAIL age_wait_stall[%0d]: got %b, expected 0", i, pipe_stall);
      end
      tick();
    end
    total++;
    if (pipe_stall !== 1'b1) begin
      bad++;
      $display("FAIL age_force_stall: got %b, expected 1", pipe_stall);
    end
    expect_wr(5'd9, 32'h99);
    tick();
    total++;
    if (pipe_stall !== 1'b0) begin
      bad++;
      $display("FAIL age_exit_stall: got %b, expected 0", pipe_stall);
    end
    expect_wr(5'd5, 32'h55);
    tick();
    pipe_valid = 1'b0;
    drain("age");
  endtask

  task automatic test_hazard();
    md_valid = 1'b1; md_waddr = 5'd6; md_wdata = 32'h66;
    tick();
    md_valid = 1'b0;
    pipe_valid = 1'b1; pipe_waddr = 5'd6; pipe_wdata = 32'h22;
    expect_wr(5'd6, 32'h66);
    #1;
    total++;
    if (pipe_stall !== 1'b1) begin
      bad++;
      $display("FAIL hazard_stall: got %b, expected 1", pipe_stall);
    end
    tick();
    total++;
    if (pipe_stall !== 1'b0) begin
      bad++;
      $display("FAIL hazard_release: got %b, expected 0", pipe_stall);
    end
    expect_wr(5'd6, 32'h22);
    tick();
    pipe_valid = 1'b0;
    drain("hazard");
    total++;
    if (rf_waddr !== 5'd6 || rf_wdata !== 32'h22) begin
      bad++;
      $display("FAIL hazard_final: addr=%0d data=%h, expected 6/00000022", rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_zero_addr();
    md_valid = 1'b1; md_waddr = 5'd0; md_wdata = 32'hDEAD;
    #1;
    total++;
    if (md_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_md_ready: got %b, expected 1", md_ready);
    end
    tick();
    total++;
    if (md_count !== 3'd0) begin
      bad++;
      $display("FAIL zero_md_discard: count=%0d, expected 0", md_count);
    end
    md_waddr = 5'd12; md_wdata = 32'hC0;
    pipe_valid = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hBAD;
    tick();
    md_valid = 1'b0;
    #1;
    total++;
    if (pipe_stall !== 1'b0 || md_count !== 3'd1) begin
      bad++;
      $display("FAIL zero_pipe: stall=%b count=%0d, expected 0/1", pipe_stall, md_count);
    end
    expect_wr(5'd12, 32'hC0);
    tick();
    total++;
    if (pipe_stall !== 1'b0 || md_count !== 3'd0) begin
      bad++;
      $display("FAIL zero_drain: stall=%b count=%0d, expected 0/0", pipe_stall, md_count);
    end
    pipe_valid = 1'b0;
    drain("zero_addr");
  endtask

  task automatic test_reset_mid();
    pipe_valid = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h2;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_waddr = 5'(13 + i); md_wdata = 32'hD0 + 32'(i);
      expect_wr(5'd2, 32'h2);
      tick();
    end
    md_valid = 1'b0;
    total++;
    if (md_count !== 3'd3) begin
      bad++;
      $display("FAIL mid_fill: count=%0d, expected 3", md_count);
    end
    @(negedge clk);
    #1;
    pipe_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (md_count !== 3'd0 || rf_we !== 1'b0 || md_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: count=%0d we=%b ready=%b stall=%b, expected 0/0/1/0",
               md_count, rf_we, md_ready, pipe_stall);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    total++;
    if (md_count !== 3'd0) begin
      bad++;
      $display("FAIL mid_after: count=%0d, expected 0", md_count);
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_md_single();
    test_force_full();
    test_age();
    test_hazard();
    test_zero_addr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
